mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/types.sv | 22 ++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/types.sv
// Shared types for the memory arbiter slice: word/strobe aliases, memory op encoding, arbiter states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package types;

   typedef logic [31:0] u32_t;
   typedef logic [3:0]  wrstb_t;

   typedef enum logic [1:0] {
      MEM_OP_NONE  = 2'd0,
      MEM_OP_LOAD  = 2'd1,
      MEM_OP_STORE = 2'd2,
      MEM_OP_RSVD  = 2'd3
   } mem_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUS_IF = 2'd1,
      BUS_DM = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (fetch, data) arbiter onto a single request/ack memory bus; data has priority, fetch wins after STARVE_LIMIT data grants.
// Latency: grant combinational in the request cycle, bus_req next cycle, rvalid the cycle after bus_ack.
// Backpressure: one transaction outstanding; requests are simply not granted until the bus is idle again.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   if_req/if_addr -> if_gnt      fetch request/grant; if_rvalid/if_rdata completion
//   dm_req/dm_op/dm_addr/dm_wdata/dm_wrstb -> dm_gnt   data request/grant; dm_rvalid/dm_rdata completion
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wrstb, bus_ack/bus_rdata   memory bus
//   bus_timeout                   sticky timeout flag
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to abort bus transactions after TIMEOUT_CYCLES without ack.
module mem_arbiter
   import types::*;
#(
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    if_req,
   input  u32_t    if_addr,
   output logic    if_gnt,
   output logic    if_rvalid,
   output u32_t    if_rdata,
   input  logic    dm_req,
   input  mem_op_e dm_op,
   input  u32_t    dm_addr,
   input  u32_t    dm_wdata,
   input  wrstb_t  dm_wrstb,
   output logic    dm_gnt,
   output logic    dm_rvalid,
   output u32_t    dm_rdata,
   output logic    bus_req,
   output logic    bus_we,
   output u32_t    bus_addr,
   output u32_t    bus_wdata,
   output wrstb_t  bus_wrstb,
   input  logic    bus_ack,
   input  u32_t    bus_rdata,
   output logic    bus_timeout
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   arb_state_e    r_state;
   arb_state_e    w_next;
   logic [SW-1:0] r_starve;
   logic          w_dm_req;
   logic          w_if_win;
   logic          w_if_gnt;
   logic          w_dm_gnt;
   logic          w_done;
   logic          w_tmo;
   u32_t          w_rdata;

   logic          r_bus_req;
   logic          r_bus_we;
   u32_t          r_bus_addr;
   u32_t          r_bus_wdata;
   wrstb_t        r_bus_wrstb;
   logic          r_if_rvalid;
   logic          r_dm_rvalid;
   u32_t          r_if_rdata;
   u32_t          r_dm_rdata;

   // A data request carrying MEM_OP_NONE is not a request at all.
   assign w_dm_req = dm_req && (dm_op != MEM_OP_NONE);
   assign w_if_win = if_req && (!w_dm_req || (r_starve == SW'(STARVE_LIMIT)));
   assign w_done   = (r_state != IDLE) && (bus_ack || w_tmo);
   assign w_rdata  = w_tmo ? 32'hFFFF_FFFF : bus_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Grants are gated by rst_n so nothing is granted while reset is held.
   always_comb begin
      w_next   = r_state;
      w_if_gnt = 1'b0;
      w_dm_gnt = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (rst_n) begin
               if (w_if_win) begin
                  w_if_gnt = 1'b1;
                  w_next   = BUS_IF;
               end else if (w_dm_req) begin
                  w_dm_gnt = 1'b1;
                  w_next   = BUS_DM;
               end
            end
         end
         BUS_IF, BUS_DM: begin
            if (bus_ack || w_tmo) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Starve counter: counts data grants that overtook a waiting fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (!if_req || w_if_gnt) begin
         r_starve <= '0;
      end else if (w_dm_gnt && (r_starve != SW'(STARVE_LIMIT))) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_wrstb <= '0;
         r_if_rvalid <= 1'b0;
         r_dm_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_dm_rvalid <= 1'b0;
         if (w_if_gnt) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
            r_bus_wrstb <= '0;
         end else if (w_dm_gnt) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= (dm_op == MEM_OP_STORE);
            r_bus_addr  <= dm_addr;
            r_bus_wdata <= dm_wdata;
            r_bus_wrstb <= dm_wrstb;
         end else if (w_done) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wrstb <= '0;
            if (r_state == BUS_IF) begin
               r_if_rvalid <= 1'b1;
               r_if_rdata  <= w_rdata;
            end else begin
               r_dm_rvalid <= 1'b1;
               // Stores return zero, except an aborted store reports the error pattern.
               r_dm_rdata  <= (r_bus_we && !w_tmo) ? '0 : w_rdata;
            end
         end
      end
   end

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_tmo_cnt;
   logic          r_timeout;

   // Fires in the TIMEOUT_CYCLES-th bus cycle if that cycle also has no ack.
   assign w_tmo = (r_state != IDLE) && !bus_ack && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
         if (w_tmo) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign bus_timeout = r_timeout;
`else
   logic w_unused_tmo;

   assign w_tmo        = 1'b0;
   assign bus_timeout  = 1'b0;
   assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

   assign if_gnt    = w_if_gnt;
   assign dm_gnt    = w_dm_gnt;
   assign if_rvalid = r_if_rvalid;
   assign if_rdata  = r_if_rdata;
   assign dm_rvalid = r_dm_rvalid;
   assign dm_rdata  = r_dm_rdata;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_wrstb = r_bus_wrstb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a completion scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;
   import types::*;

   logic    clk;
   logic    rst_n;
   logic    if_req;
   u32_t    if_addr;
   logic    if_gnt;
   logic    if_rvalid;
   u32_t    if_rdata;
   logic    dm_req;
   mem_op_e dm_op;
   u32_t    dm_addr;
   u32_t    dm_wdata;
   wrstb_t  dm_wrstb;
   logic    dm_gnt;
   logic    dm_rvalid;
   u32_t    dm_rdata;
   logic    bus_req;
   logic    bus_we;
   u32_t    bus_addr;
   u32_t    bus_wdata;
   wrstb_t  bus_wrstb;
   logic    bus_ack;
   u32_t    bus_rdata;
   logic    bus_timeout;

   typedef struct packed {
      logic        is_dm;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_op(dm_op), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wrstb(dm_wrstb),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wrstb(bus_wrstb),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Completion monitor: every rvalid pulse must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (if_rvalid || dm_rvalid) begin
         if (sb_q.size() == 0) begin
            chk("rvalid_unexpected", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("rvalid_both", 32'(if_rvalid && dm_rvalid), 32'd0);
            chk("rvalid_port", 32'(dm_rvalid), 32'(e.is_dm));
            chk("rvalid_rdata", dm_rvalid ? dm_rdata : if_rdata, e.data);
         end
      end
   end

   initial begin
      int g;
      g = 0;
      rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h100;
      dm_req = 1'b1; dm_op = MEM_OP_LOAD; dm_addr = 32'h0; dm_wdata = 32'hFFFF_FFFF; dm_wrstb = 4'hF;
      bus_ack = 1'b1; bus_rdata = 32'h0;

      // Reset: requests present but nothing may be granted or driven.
      repeat (2) nxt();
      mid();
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_rvalid", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
      chk("rst_timeout", 32'(bus_timeout), 32'd0);
      nxt();
      rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_op = MEM_OP_NONE; bus_ack = 1'b0;

      // Fetch only.
      nxt(); if_req = 1'b1; if_addr = 32'h100; mid();
      chk("f_if_gnt", 32'(if_gnt), 32'd1);
      chk("f_dm_gnt", 32'(dm_gnt), 32'd0);
      sb_q.push_back(exp_t'{is_dm: 1'b0, data: 32'hA5A5_0001});
      nxt(); if_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hA5A5_0001; mid();
      chk("f_bus_req", 32'(bus_req), 32'd1);
      chk("f_bus_addr", bus_addr, 32'h100);
      chk("f_bus_we", 32'(bus_we), 32'd0);
      chk("f_bus_wrstb", 32'(bus_wrstb), 32'd0);
      chk("f_bus_wdata", bus_wdata, 32'd0);
      nxt(); bus_ack = 1'b0; bus_rdata = 32'h0; mid();
      chk("f_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("f_bus_req_off", 32'(bus_req), 32'd0);
      nxt(); mid();
      chk("f_rvalid_pulse", 32'(if_rvalid), 32'd0);
      chk("f_rdata_hold", if_rdata, 32'hA5A5_0001);

      // Simultaneous fetch and data load: data first.
      nxt(); if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_op = MEM_OP_LOAD; dm_addr = 32'h200; mid();
      chk("s_dm_gnt", 32'(dm_gnt), 32'd1);
      chk("s_if_gnt", 32'(if_gnt), 32'd0);
      sb_q.push_back(exp_t'{is_dm: 1'b1, data: 32'h1111_2222});
      nxt(); dm_req = 1'b0; dm_op = MEM_OP_NONE; bus_ack = 1'b1; bus_rdata = 32'h1111_2222; mid();
      chk("s_bus_addr", bus_addr, 32'h200);
      chk("s_bus_we", 32'(bus_we), 32'd0);
      chk("s_if_gnt_busy", 32'(if_gnt), 32'd0);
      nxt(); bus_ack = 1'b0; mid();
      chk("s_dm_rvalid", 32'(dm_rvalid), 32'd1);
      chk("s_if_gnt_next", 32'(if_gnt), 32'd1);
      sb_q.push_back(exp_t'{is_dm: 1'b0, data: 32'h3333_4444});
      nxt(); bus_ack = 1'b1; bus_rdata = 32'h3333_4444; mid();
      chk("s_bus_addr_if", bus_addr, 32'h300);
      nxt(); bus_ack = 1'b0; if_req = 1'b0; dm_req = 1'b1; dm_op = MEM_OP_NONE; mid();
      chk("s_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("none_op_no_gnt", 32'(dm_gnt), 32'd0);

      // Starvation: ack held high (ignored in IDLE), grants every other cycle.
      for (int i = 0; i < 12; i++) begin
         nxt();
         if (i == 0) begin
            if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_op = MEM_OP_LOAD; dm_addr = 32'h600; bus_ack = 1'b1;
         end
         bus_rdata = 32'hC0DE_0000 + i;
         mid();
         if (i % 2 == 0) begin
            g = i / 2;
            chk($sformatf("starve_dm_gnt%0d", g), 32'(dm_gnt), 32'(g != 4));
            chk($sformatf("starve_if_gnt%0d", g), 32'(if_gnt), 32'(g == 4));
            sb_q.push_back(exp_t'{is_dm: (g != 4), data: 32'hC0DE_0000 + i + 1});
         end else begin
            chk($sformatf("starve_bus_addr%0d", g), bus_addr, (g == 4) ? 32'h500 : 32'h600);
         end
      end
      nxt(); if_req = 1'b0; dm_req = 1'b0; dm_op = MEM_OP_NONE; bus_ack = 1'b0; mid();
      chk("starve_last_rvalid", 32'(dm_rvalid), 32'd1);

      // Store with ack after three bus cycles; inputs change underneath.
      nxt(); dm_req = 1'b1; dm_op = MEM_OP_STORE; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
      dm_wrstb = 4'b0011; bus_rdata = 32'h1234_5678; mid();
      chk("st_dm_gnt", 32'(dm_gnt), 32'd1);
      sb_q.push_back(exp_t'{is_dm: 1'b1, data: 32'h0});
      for (int k = 1; k <= 3; k++) begin
         nxt(); dm_req = 1'b0; dm_op = MEM_OP_NONE; dm_addr = 32'hFFFF_FFF0; dm_wdata = 32'h0;
         dm_wrstb = 4'hC; bus_ack = (k == 3); mid();
         chk($sformatf("st_bus_req%0d", k), 32'(bus_req), 32'd1);
         chk($sformatf("st_bus_addr%0d", k), bus_addr, 32'h40);
         chk($sformatf("st_bus_we%0d", k), 32'(bus_we), 32'd1);
         chk($sformatf("st_bus_wdata%0d", k), bus_wdata, 32'hDEAD_BEEF);
         chk($sformatf("st_bus_wrstb%0d", k), 32'(bus_wrstb), 32'h3);
      end
      nxt(); bus_ack = 1'b0; mid();
      chk("st_dm_rvalid", 32'(dm_rvalid), 32'd1);
      chk("st_bus_req_off", 32'(bus_req), 32'd0);

      // Reset in the middle of a data transaction.
      nxt(); dm_req = 1'b1; dm_op = MEM_OP_LOAD; dm_addr = 32'h80; mid();
      chk("rs_dm_gnt", 32'(dm_gnt), 32'd1);
      nxt(); dm_req = 1'b0; dm_op = MEM_OP_NONE; mid();
      chk("rs_bus_req", 32'(bus_req), 32'd1);
      #1; rst_n = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA; #1;
      chk("rs_bus_req_async", 32'(bus_req), 32'd0);
      nxt(); mid();
      chk("rs_dm_rvalid_in_rst", 32'(dm_rvalid), 32'd0);
      nxt(); rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mid();
         chk($sformatf("rs_no_rvalid%0d", k), 32'(dm_rvalid), 32'd0);
         nxt();
      end
      bus_ack = 1'b0;

`ifdef MEM_ARBITER_TIMEOUT_EN
      // Never acked: abort after 64 bus cycles, sticky flag until reset.
      nxt(); dm_req = 1'b1; dm_op = MEM_OP_LOAD; dm_addr = 32'h90; mid();
      chk("to_dm_gnt", 32'(dm_gnt), 32'd1);
      sb_q.push_back(exp_t'{is_dm: 1'b1, data: 32'hFFFF_FFFF});
      for (int k = 1; k <= 64; k++) begin
         nxt(); dm_req = 1'b0; dm_op = MEM_OP_NONE; mid();
         chk($sformatf("to_bus_req%0d", k), 32'(bus_req), 32'd1);
      end
      chk("to_flag_early", 32'(bus_timeout), 32'd0);
      nxt(); mid();
      chk("to_dm_rvalid", 32'(dm_rvalid), 32'd1);
      chk("to_flag", 32'(bus_timeout), 32'd1);
      chk("to_bus_req_off", 32'(bus_req), 32'd0);
      repeat (5) nxt();
      mid();
      chk("to_flag_sticky", 32'(bus_timeout), 32'd1);
      nxt(); rst_n = 1'b0; mid();
      chk("to_flag_rst", 32'(bus_timeout), 32'd0);
      nxt(); rst_n = 1'b1;
`else
      // No timeout: the bus waits indefinitely for ack.
      nxt(); dm_req = 1'b1; dm_op = MEM_OP_LOAD; dm_addr = 32'h90; mid();
      chk("nt_dm_gnt", 32'(dm_gnt), 32'd1);
      sb_q.push_back(exp_t'{is_dm: 1'b1, data: 32'h0BAD_F00D});
      for (int k = 1; k <= 80; k++) begin
         nxt(); dm_req = 1'b0; dm_op = MEM_OP_NONE; mid();
         if (k % 20 == 0) begin
            chk($sformatf("nt_bus_req%0d", k), 32'(bus_req), 32'd1);
            chk($sformatf("nt_flag%0d", k), 32'(bus_timeout), 32'd0);
         end
      end
      nxt(); bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D; mid();
      nxt(); bus_ack = 1'b0; mid();
      chk("nt_dm_rvalid", 32'(dm_rvalid), 32'd1);
`endif

      nxt(); nxt(); mid();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
